// File: rtl/io_irq_ctrl.sv
// GBA interrupt controller: IE/IF/IME registers, edge capture of peripheral events,
// pipelined IRQ output and HALTCNT halt with wake-on-interrupt.
module io_irq_ctrl #(
  parameter int unsigned IRQ_LATENCY = 2,
  parameter int unsigned NUM_SRC     = 14
) (
  input  logic               clk_mem,
  input  logic               rst_n,
  input  logic [23:0]        addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  input  logic               read,
  input  logic               write,
  input  logic [1:0]         width,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq,
  output logic               halt
);

  typedef enum logic {StRun, StHalt} state_e;

  localparam logic [9:0] IdxIrq  = 10'h080;  // 0x200
  localparam logic [9:0] IdxIme  = 10'h082;  // 0x208
  localparam logic [9:0] IdxHalt = 10'h0c0;  // 0x300

  logic [4:0]               shift;
  logic [31:0]              base_mask, mask, wdata;
  logic                     hit_irq, hit_ime, hit_halt, halt_wr;
  logic [NUM_SRC-1:0]       ie_q, ie_d, if_q, if_d, prev_q, clr, rise;
  logic                     ime_q, ime_d, pend, wake;
  logic [IRQ_LATENCY-1:0]   pipe_q;
  logic [15:0]              ie_ext, if_ext;
  logic [31:0]              rd_word;
  state_e                   state_q;

  assign shift = {addr[1:0], 3'b000};

  always_comb begin
    unique case (width)
      2'b00:   base_mask = 32'h0000_00ff;
      2'b01:   base_mask = 32'h0000_ffff;
      default: base_mask = 32'hffff_ffff;
    endcase
  end

  assign mask  = base_mask << shift;
  assign wdata = (data_in << shift) & mask;

  assign hit_irq  = write && (addr[11:2] == IdxIrq);
  assign hit_ime  = write && (addr[11:2] == IdxIme);
  assign hit_halt = write && (addr[11:2] == IdxHalt);
  // Bit 15 set selects STOP, which this controller ignores.
  assign halt_wr  = hit_halt && mask[8] && !wdata[15];

  assign ie_d  = hit_irq ? ((ie_q & ~mask[NUM_SRC-1:0]) | wdata[NUM_SRC-1:0]) : ie_q;
  assign clr   = hit_irq ? wdata[16 +: NUM_SRC] : '0;
  assign rise  = irq_src & ~prev_q;
  // New edges are OR-ed in after the clear so a simultaneous W1C never drops an event.
  assign if_d  = (if_q & ~clr) | rise;
  assign ime_d = (hit_ime && mask[0]) ? wdata[0] : ime_q;

  assign wake = |(ie_q & if_q);
  assign pend = ime_q & wake;

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      ie_q    <= '0;
      if_q    <= '0;
      prev_q  <= '0;
      ime_q   <= 1'b0;
      pipe_q  <= '0;
      state_q <= StRun;
    end else begin
      ie_q   <= ie_d;
      if_q   <= if_d;
      prev_q <= irq_src;
      ime_q  <= ime_d;
      pipe_q[0] <= pend;
      for (int i = 1; i < IRQ_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      unique case (state_q)
        StRun:   if (halt_wr) state_q <= StHalt;
        StHalt:  if (!halt_wr && wake) state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

  assign irq  = pipe_q[IRQ_LATENCY-1];
  assign halt = (state_q == StHalt);

  always_comb begin
    ie_ext = '0;
    if_ext = '0;
    ie_ext[NUM_SRC-1:0] = ie_q;
    if_ext[NUM_SRC-1:0] = if_q;
    unique case (addr[11:2])
      IdxIrq:  rd_word = {if_ext, ie_ext};
      IdxIme:  rd_word = {31'b0, ime_q};
      default: rd_word = 32'b0;
    endcase
  end

  assign data_out = rd_word >> shift;

  logic unused_bits;
  assign unused_bits = ^{read, addr[23:12], wdata};

endmodule

// File: tb/tb_io_irq_ctrl.sv
// Self-checking bench for io_irq_ctrl: directed plan plus randomized traffic against
// a register-level model.
module tb_io_irq_ctrl;
  localparam int L = 2;
  localparam int N = 14;

  logic          clk_mem = 1'b0;
  logic          rst_n   = 1'b0;
  logic [23:0]   addr    = 24'h200;
  logic [31:0]   data_in = '0;
  logic [31:0]   data_out;
  logic          read    = 1'b0;
  logic          write   = 1'b0;
  logic [1:0]    width   = 2'b10;
  logic [N-1:0]  irq_src = '0;
  logic          irq, halt;

  io_irq_ctrl #(.IRQ_LATENCY(L), .NUM_SRC(N)) dut (
    .clk_mem(clk_mem), .rst_n(rst_n), .addr(addr), .data_in(data_in),
    .data_out(data_out), .read(read), .write(write), .width(width),
    .irq_src(irq_src), .irq(irq), .halt(halt)
  );

  always #5 clk_mem = ~clk_mem;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state
  int unsigned m_ie, m_if, m_ime, m_prev;
  bit          m_halt;
  bit          m_pend[L];
  localparam int unsigned AllSrc = (1 << N) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read();
    int unsigned w;
    if (addr[11:0] >= 12'h200 && addr[11:0] < 12'h204)      w = (m_if << 16) | m_ie;
    else if (addr[11:0] >= 12'h208 && addr[11:0] < 12'h20c) w = m_ime;
    else                                                    w = 0;
    return w >> (addr[1:0] * 8);
  endfunction

  task automatic m_reset();
    m_ie = 0; m_if = 0; m_ime = 0; m_prev = 0; m_halt = 0;
    for (int i = 0; i < L; i++) m_pend[i] = 0;
  endtask

  // Next model state from the inputs presented before the coming edge.
  task automatic tick();
    int unsigned sh, mask, wd, rise, clr, n_ie, n_ime, word;
    bit halt_wr, pend, wake;
    sh      = addr[1:0] * 8;
    mask    = (width == 2'b00) ? 32'hff : (width == 2'b01) ? 32'hffff : 32'hffff_ffff;
    mask    = mask << sh;
    wd      = (data_in << sh) & mask;
    word    = addr[11:0] / 4;
    clr     = 0;
    n_ie    = m_ie;
    n_ime   = m_ime;
    halt_wr = 0;
    if (write) begin
      if (word == 'h80) begin
        n_ie = ((m_ie & ~mask) | wd) & AllSrc;
        clr  = (wd >> 16) & AllSrc;
      end
      if (word == 'h82 && mask[0]) n_ime = wd & 1;
      if (word == 'hc0 && mask[8] && wd[15] == 1'b0) halt_wr = 1;
    end
    rise = irq_src & ~m_prev & AllSrc;
    wake = (m_ie & m_if) != 0;
    pend = (m_ime != 0) && wake;
    @(posedge clk_mem);
    if (!rst_n) begin
      m_reset();
    end else begin
      for (int i = L - 1; i > 0; i--) m_pend[i] = m_pend[i-1];
      m_pend[0] = pend;
      m_if   = ((m_if & ~clr) | rise) & AllSrc;
      m_ie   = n_ie;
      m_ime  = n_ime;
      m_prev = irq_src;
      if (halt_wr) m_halt = 1;
      else if (m_halt && wake) m_halt = 0;
    end
    @(negedge clk_mem);
    #1;
  endtask

  always @(negedge clk_mem) begin
    if (cmp_en) begin
      check("data_out", data_out, m_read());
      check("irq", {31'b0, irq}, {31'b0, m_pend[L-1]});
      check("halt", {31'b0, halt}, {31'b0, m_halt});
    end
  end

  task automatic wr(input logic [23:0] a, input logic [1:0] w, input logic [31:0] d);
    addr = a; width = w; data_in = d; write = 1'b1;
    tick();
    write = 1'b0; addr = 24'h200; width = 2'b10;
  endtask

  initial begin
    m_reset();
    #23;
    check("reset_data", data_out, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_halt", {31'b0, halt}, 32'h0);
    @(negedge clk_mem); #1;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // IE bit3, IME, then a one-cycle pulse on timer0 overflow
    wr(24'h200, 2'b01, 32'h0008);
    wr(24'h208, 2'b10, 32'h1);
    irq_src = 14'h0008;
    tick();
    irq_src = '0;
    check("if_set", data_out, 32'h0008_0008);
    check("irq_lat0", {31'b0, irq}, 32'h0);
    tick();
    check("irq_lat1", {31'b0, irq}, 32'h0);
    tick();
    check("irq_lat2", {31'b0, irq}, 32'h1);

    // Clear racing a new rise: set wins; a later clear with the line held stays clear
    irq_src = 14'h0008;
    addr = 24'h202; width = 2'b01; data_in = 32'h0008; write = 1'b1;
    tick();
    check("set_wins", data_out, 32'h0000_0008);
    wr(24'h202, 2'b01, 32'h0008);
    tick();
    check("held_no_reset", data_out, 32'h0000_0008);

    // Byte W1C on the upper IF byte
    irq_src = '0;
    tick();
    irq_src = 14'h0108;
    tick();
    irq_src = '0;
    check("if_0108", data_out, 32'h0108_0008);
    wr(24'h203, 2'b00, 32'h01);
    tick();
    check("byte_w1c", data_out, 32'h0008_0008);

    // Halt, then wake on VBlank with IME off
    wr(24'h200, 2'b01, 32'h0001);
    wr(24'h208, 2'b10, 32'h0);
    wr(24'h202, 2'b01, 32'hffff);
    wr(24'h301, 2'b00, 32'h00);
    check("halt_enter", {31'b0, halt}, 32'h1);
    tick();
    irq_src = 14'h0001;
    tick();
    irq_src = '0;
    check("halt_hold", {31'b0, halt}, 32'h1);
    tick();
    check("halt_wake", {31'b0, halt}, 32'h0);
    check("irq_no_ime", {31'b0, irq}, 32'h0);

    // STOP is ignored; halt with wake already true lasts one cycle
    wr(24'h301, 2'b00, 32'h80);
    check("stop_noop", {31'b0, halt}, 32'h0);
    wr(24'h301, 2'b00, 32'h00);
    check("halt_one", {31'b0, halt}, 32'h1);
    tick();
    check("halt_one_exit", {31'b0, halt}, 32'h0);

    // Reset while halted
    wr(24'h202, 2'b01, 32'hffff);
    wr(24'h301, 2'b00, 32'h00);
    check("halt_again", {31'b0, halt}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_regs", data_out, 32'h0);
    @(negedge clk_mem); #1;
    rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: addr = 24'h200 | 24'($urandom_range(0, 3));
        3, 4:    addr = 24'h208 | 24'($urandom_range(0, 3));
        5:       addr = 24'h300 | 24'($urandom_range(0, 3));
        default: addr = 24'($urandom);
      endcase
      width   = 2'($urandom);
      data_in = $urandom;
      write   = ($urandom_range(0, 9) < 3);
      read    = ~write;
      if (sel == 5 && $urandom_range(0, 3) != 0) data_in[15] = 1'b1;
      irq_src = irq_src ^ N'($urandom & $urandom & $urandom);
      if (c % 500 == 499) begin
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("rand_rst_halt", {31'b0, halt}, 32'h0);
        check("rand_rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk_mem); #1;
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_irq_ctrl.md
Name: io_irq_ctrl

Overview:
- GBA interrupt controller in the I/O register space, directly downstream of the timer/I-O register block.
- Consumes timer overflow strobes and other peripheral event lines, and latches them into IF.
- Gates IF with IE and IME to drive the CPU IRQ line.
- Implements HALTCNT low-power halt with wake-on-interrupt.
- Shares the I/O bus (addr/data_in/data_out/read/write/width) with the timer block; decodes addr[11:0] only.

Parameters:
- IRQ_LATENCY, 2, register stages from IF/IE/IME state to irq output (legal 1..4).
- NUM_SRC, 14, number of interrupt source lines (IF/IE bits 0..13; bits 15:14 read 0).

Ports:
- clk_mem  in  1  system/memory clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  24  byte address; only addr[11:0] decoded.
- data_in  in  32  write data, lane-aligned to the access (byte/half in low bits).
- data_out  out  32  read data, combinational, right-shifted by addr[1:0]*8.
- read  in  1  read strobe (no side effects).
- write  in  1  write strobe, one access per cycle.
- width  in  2  00 byte, 01 halfword, 1x word.
- irq_src  in  NUM_SRC  level event lines; bit0 VBlank, 1 HBlank, 2 VCount, 3..6 timer0..3 overflow, 7 serial, 8..11 DMA0..3, 12 keypad, 13 gamepak.
- irq  out  1  CPU IRQ request, level, active high.
- halt  out  1  CPU halt request, active high.

Behaviour:
- Reset (async, rst_n=0): IE=0, IF=0, IME=0, edge-detect history=0, IRQ pipeline=0, FSM=RUN.
  - Outputs: irq=0, halt=0, data_out reflects zeroed registers.
- Register map (word index addr[11:2]):
  - 0x200 = {IF, IE}.
  - 0x208 = {31'b0, IME}.
  - 0x300 = {16'b0, HALTCNT byte at 0x301, 8'b0}, reads 0.
  - All others read 0; writes to them are ignored.
- Write lane mask:
  - mask = 0xff / 0xffff / 0xffffffff by width, then shifted left by addr[1:0]*8.
  - Write data = (data_in << shift) & mask.
- IE: masked bits replaced with write data.
- IF: write-1-to-clear on masked bits; 0 bits leave IF unchanged.
- IME: bit 0 replaced when the mask covers bit 0.
- Source capture:
  - rise[i] = irq_src[i] & ~prev[i], with prev registered every cycle.
  - IF_next = (IF & ~clear) | rise.
  - Set wins over a simultaneous clear of the same bit, so no event is lost.
  - A source held high sets IF once only.
  - Capture is independent of IE and IME.
- IRQ path:
  - pend = IME & |(IE & IF), registered through IRQ_LATENCY stages.
  - irq rises IRQ_LATENCY cycles after the IF/IE/IME update that makes pend true.
  - irq deasserts the same number of cycles after pend goes false.
- Halt FSM: states RUN, HALT.
  - RUN -> HALT: write whose mask covers byte 0x301 and whose written bit 15 (of the word) is 0.
  - Writing bit 15 = 1 (STOP) is a no-op.
  - HALT -> RUN: the first cycle where |(IE & IF) = 1; IME is ignored.
  - If the wake condition holds at entry, the FSM stays in HALT exactly one cycle.
  - halt = (state == HALT), registered.
  - A halt write while already in HALT keeps HALT.
- Simultaneous write and source edge: both are applied in the same cycle per the rules above.
- Reset mid-halt: returns to RUN immediately and halt=0.
- data_out is combinational from the current registers; read has no side effects.

Test Plan:
- Reset, then read 0x200 word -> data_out=0x00000000; irq=0, halt=0.
- Write IE=0x0008 (half @0x200), IME=1 (@0x208), pulse irq_src[3] one cycle -> IF=0x0008 next cycle; irq=1 exactly 2 cycles after the IF update.
- Hold irq_src[3] high, write half 0x202=0x0008 in the same cycle as a new rise on bit 3 -> IF bit3 stays 1; a later W1C with the source still high -> IF=0, not re-set.
- Byte write 0x203=0x01 with IF=0x0108 -> IF=0x0008; word read 0x200 -> 0x00080008 (with IE=0x0008).
- IE=0x0001, IME=0, byte write 0x301=0x00 -> halt=1 next cycle; pulse irq_src[0] -> halt drops the cycle after IF bit0 sets, irq stays 0.
- Byte write 0x301=0x80 -> halt stays 0; assert rst_n=0 while in HALT -> halt=0, IE=IF=IME=0 immediately.
